// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types: the common data bus payload and default sizing.
package lc3b_types;

  localparam int unsigned NUM_RS_DEFAULT = 4;
  localparam int unsigned CDB_DATA_W     = 16;
  localparam int unsigned CDB_TAG_W      = 3;

  typedef struct packed {
    logic                  valid;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
  } cdb_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating priority encoder: first set bit of req_i at or above
// ptr_i, wrapping N-1 -> 0. Shared by CDB arbitration and issue selection.
module rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [PTR_W-1:0] winner_c,
  output logic             any_valid_c
);

  localparam int unsigned IW = PTR_W + 1;

  logic [IW-1:0] idx;

  always_comb begin
    winner_c    = '0;
    any_valid_c = 1'b0;
    idx         = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = IW'(ptr_i) + IW'(k);
      if (idx >= IW'(N)) begin
        idx = idx - IW'(N);
      end
      if (!any_valid_c && req_i[idx[PTR_W-1:0]]) begin
        any_valid_c = 1'b1;
        winner_c    = idx[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter driving the registered common data bus from the
// reservation stations. Define CDB_FIXED_PRIO_EN for lowest-index-wins.
module cdb_arbiter
  import lc3b_types::*;
#(
  parameter int unsigned NUM_RS     = NUM_RS_DEFAULT,
  parameter int unsigned data_width = CDB_DATA_W,
  parameter int unsigned tag_width  = CDB_TAG_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [NUM_RS-1:0]            done,
  input  logic [NUM_RS*data_width-1:0] rs_data,
  input  logic [NUM_RS*tag_width-1:0]  rs_tag,
  output logic [NUM_RS-1:0]            grant,
  output cdb_t                         CDB_out
);

  localparam int unsigned PTR_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

  logic [NUM_RS-1:0]     grant_q, grant_d;
  cdb_t                  cdb_q, cdb_d;
  logic [NUM_RS-1:0]     req_c;
  logic [PTR_W-1:0]      ptr_c;
  logic [PTR_W-1:0]      winner_c;
  logic                  any_valid_c;
  logic [data_width-1:0] data_a [NUM_RS];
  logic [tag_width-1:0]  tag_a  [NUM_RS];

  for (genvar i = 0; i < NUM_RS; i++) begin : g_unpack
    assign data_a[i] = rs_data[i*data_width +: data_width];
    assign tag_a[i]  = rs_tag[i*tag_width +: tag_width];
  end

  // A station granted last edge still shows done until its busy bit clears.
  assign req_c = done & ~grant_q;

`ifdef CDB_FIXED_PRIO_EN
  assign ptr_c = '0;
`else
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  assign ptr_c = rr_ptr_q;
`endif

  rr_pick #(
    .N     (NUM_RS),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req_i       (req_c),
    .ptr_i       (ptr_c),
    .winner_c    (winner_c),
    .any_valid_c (any_valid_c)
  );

  // Next-state: valid/grant default low, tag/data hold when idle.
  always_comb begin
    grant_d       = '0;
    cdb_d         = cdb_q;
    cdb_d.valid   = 1'b0;
`ifndef CDB_FIXED_PRIO_EN
    rr_ptr_d      = rr_ptr_q;
`endif
    if (!flush && any_valid_c) begin
      grant_d[winner_c] = 1'b1;
      cdb_d.valid       = 1'b1;
      cdb_d.tag         = CDB_TAG_W'(tag_a[winner_c]);
      cdb_d.data        = CDB_DATA_W'(data_a[winner_c]);
`ifndef CDB_FIXED_PRIO_EN
      rr_ptr_d          = (winner_c == PTR_W'(NUM_RS - 1)) ? '0 : winner_c + PTR_W'(1);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q  <= '0;
      cdb_q    <= '0;
`ifndef CDB_FIXED_PRIO_EN
      rr_ptr_q <= '0;
`endif
    end else begin
      grant_q  <= grant_d;
      cdb_q    <= cdb_d;
`ifndef CDB_FIXED_PRIO_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

  assign grant   = grant_q;
  assign CDB_out = cdb_q;

endmodule
